addsub_pipe_nb: RTL and testbench



---
 rtl/addsub_pipe_nb_if.sv | 27 ++
 rtl/addsub_pipe_nb.sv | 93 +++++++++
 tb/tb_addsub_pipe_nb.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_pipe_nb_if.sv
// Handshake and data bundle for the pipelined add/subtract block.
// The master drives the operands and out_ready. The slave returns in_ready and the result.
interface addsub_pipe_nb_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/addsub_pipe_nb.sv
// Pipelined WIDTH-bit add/subtract built from STAGES ripple chunks.
// A registered carry links the chunks, and a global stall holds every stage when the output is blocked.
module addsub_pipe_nb #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input logic             clk,
  input logic             rst_n,
  addsub_pipe_nb_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  logic [WIDTH-1:0]  a_r     [STAGES];
  logic [WIDTH-1:0]  b_r     [STAGES];
  logic [WIDTH-1:0]  sum_r   [STAGES];
  logic [STAGES-1:0] carry_r;
  logic [STAGES-1:0] valid_r;
  logic              ovf_r;

  logic [WIDTH-1:0]  in_a_s   [STAGES];
  logic [WIDTH-1:0]  in_b_s   [STAGES];
  logic [WIDTH-1:0]  in_sum_s [STAGES];
  logic [STAGES-1:0] in_c_s;
  logic [STAGES-1:0] in_v_s;
  logic [WIDTH-1:0]  sum_nx_s [STAGES];
  logic [STAGES-1:0] carry_nx_s;
  logic              ovf_nx_s;
  logic              advance_s;

  // Route the inputs of each stage. Stage 0 takes the port, with b and c_in inverted for subtract.
  always_comb begin
    advance_s   = !valid_r[STAGES-1] || bus.out_ready;
    in_a_s[0]   = bus.a;
    in_b_s[0]   = {WIDTH{bus.sub}} ^ bus.b;
    in_sum_s[0] = {WIDTH{1'b0}};
    in_c_s[0]   = bus.c_in ^ bus.sub;
    in_v_s[0]   = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      in_a_s[k]   = a_r[k-1];
      in_b_s[k]   = b_r[k-1];
      in_sum_s[k] = sum_r[k-1];
      in_c_s[k]   = carry_r[k-1];
      in_v_s[k]   = valid_r[k-1];
    end
  end

  // Ripple-add chunk k in stage k. Overflow needs the MSB operands, so it is computed in the last stage.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum_nx_s[k] = in_sum_s[k];
      {carry_nx_s[k], sum_nx_s[k][k*CHUNK +: CHUNK]} =
          {1'b0, in_a_s[k][k*CHUNK +: CHUNK]} +
          {1'b0, in_b_s[k][k*CHUNK +: CHUNK]} +
          {{CHUNK{1'b0}}, in_c_s[k]};
    end
    // The carry into the MSB equals a ^ b ^ sum at that bit.
    ovf_nx_s = in_a_s[STAGES-1][WIDTH-1] ^ in_b_s[STAGES-1][WIDTH-1] ^
               sum_nx_s[STAGES-1][WIDTH-1] ^ carry_nx_s[STAGES-1];
  end

  // Stage registers: cleared on reset, advanced together, and written only when a valid operand arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= {STAGES{1'b0}};
      carry_r <= {STAGES{1'b0}};
      ovf_r   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k]   <= {WIDTH{1'b0}};
        b_r[k]   <= {WIDTH{1'b0}};
        sum_r[k] <= {WIDTH{1'b0}};
      end
    end else if (advance_s) begin
      valid_r <= in_v_s;
      for (int k = 0; k < STAGES; k++) begin
        if (in_v_s[k]) begin
          a_r[k]     <= in_a_s[k];
          b_r[k]     <= in_b_s[k];
          sum_r[k]   <= sum_nx_s[k];
          carry_r[k] <= carry_nx_s[k];
        end
      end
      if (in_v_s[STAGES-1]) begin
        ovf_r <= ovf_nx_s;
      end
    end
  end

  assign bus.in_ready  = advance_s & rst_n;
  assign bus.out_valid = valid_r[STAGES-1];
  assign bus.sum       = sum_r[STAGES-1];
  assign bus.c_out     = carry_r[STAGES-1];
  assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_addsub_pipe_nb.sv
// Directed bench for the pipelined add/subtract, plus a randomised 16-bit sweep over STAGES = 1, 4 and 16.
module tb_addsub_pipe_nb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int passes = 0;
  int fails = 0;

  always #5 clk = ~clk;

  addsub_pipe_nb_if #(.WIDTH(8)) m8 ();
  addsub_pipe_nb #(.WIDTH(8), .STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(m8.slave));

  logic        sw_in_valid = 1'b0;
  logic        sw_out_ready = 1'b1;
  logic [15:0] sw_a = 16'h0000;
  logic [15:0] sw_b = 16'h0000;
  logic        sw_cin = 1'b0;
  logic        sw_sub = 1'b0;
  logic        sw_rdy [3];
  logic        sw_ov  [3];
  logic [17:0] sw_res [3];
  logic [17:0] sw_q   [3][$];

  addsub_pipe_nb_if #(.WIDTH(16)) s1 ();
  addsub_pipe_nb_if #(.WIDTH(16)) s4 ();
  addsub_pipe_nb_if #(.WIDTH(16)) s16 ();
  addsub_pipe_nb #(.WIDTH(16), .STAGES(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(s1.slave));
  addsub_pipe_nb #(.WIDTH(16), .STAGES(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(s4.slave));
  addsub_pipe_nb #(.WIDTH(16), .STAGES(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(s16.slave));

  assign s1.in_valid = sw_in_valid;   assign s4.in_valid = sw_in_valid;   assign s16.in_valid = sw_in_valid;
  assign s1.a = sw_a;                 assign s4.a = sw_a;                 assign s16.a = sw_a;
  assign s1.b = sw_b;                 assign s4.b = sw_b;                 assign s16.b = sw_b;
  assign s1.c_in = sw_cin;            assign s4.c_in = sw_cin;            assign s16.c_in = sw_cin;
  assign s1.sub = sw_sub;             assign s4.sub = sw_sub;             assign s16.sub = sw_sub;
  assign s1.out_ready = sw_out_ready; assign s4.out_ready = sw_out_ready; assign s16.out_ready = sw_out_ready;
  assign sw_rdy[0] = s1.in_ready;     assign sw_rdy[1] = s4.in_ready;     assign sw_rdy[2] = s16.in_ready;
  assign sw_ov[0] = s1.out_valid;     assign sw_ov[1] = s4.out_valid;     assign sw_ov[2] = s16.out_valid;
  assign sw_res[0] = {s1.ovf, s1.c_out, s1.sum};
  assign sw_res[1] = {s4.ovf, s4.c_out, s4.sum};
  assign sw_res[2] = {s16.ovf, s16.c_out, s16.sum};

  // Reference result {ovf, c_out, sum}, masked to w bits and computed at full width.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [16:0] mask, beff, t;
    logic [15:0] s;
    logic        c, o;
    mask = (17'd1 << w) - 17'd1;
    beff = sub ? (~{1'b0, b}) & mask : {1'b0, b} & mask;
    t    = {1'b0, a} + beff + {16'd0, cin ^ sub};
    s    = t[15:0] & mask[15:0];
    c    = t[w];
    o    = (a[w-1] == beff[w-1]) && (s[w-1] != a[w-1]);
    return {o, c, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One isolated operation: accepted at edge N, invalid after N, valid with the result after N+1.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic sub, input logic [7:0] es, input logic ec, input logic eo);
    @(negedge clk);
    m8.a = a; m8.b = b; m8.c_in = cin; m8.sub = sub; m8.in_valid = 1'b1; m8.out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, 32'(m8.in_ready), 32'd1);
    @(posedge clk);
    #1 chk({tag, "_early_valid"}, 32'(m8.out_valid), 32'd0);
    @(negedge clk);
    m8.in_valid = 1'b0;
    @(posedge clk);
    #1 chk({tag, "_valid"}, 32'(m8.out_valid), 32'd1);
    chk({tag, "_result"}, {22'd0, m8.ovf, m8.c_out, m8.sum}, {22'd0, eo, ec, es});
  endtask

  task automatic flush8();
    @(negedge clk);
    m8.in_valid = 1'b0; m8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  // At the negedge, take the output handshakes of all sweep DUTs, then record their accepts.
  task automatic sweep_cycle(input string tag);
    #1;
    for (int j = 0; j < 3; j++) begin
      if (sw_ov[j] && sw_out_ready) begin
        chk({tag, "_nonempty"}, 32'(sw_q[j].size() != 0), 32'd1);
        if (sw_q[j].size() != 0) chk({tag, "_result"}, 32'(sw_res[j]), 32'(sw_q[j].pop_front()));
      end
      if (sw_in_valid && sw_rdy[j]) sw_q[j].push_back(model(16, sw_a, sw_b, sw_cin, sw_sub));
    end
  endtask

  logic [7:0]  st_a   [6] = '{8'h01, 8'h10, 8'hF0, 8'h33, 8'h40, 8'h00};
  logic [7:0]  st_b   [6] = '{8'h02, 8'h20, 8'h20, 8'h11, 8'h40, 8'h00};
  logic        st_cin [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        st_sub [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0]  bp_a   [4] = '{8'h11, 8'h50, 8'h80, 8'h12};
  logic [7:0]  bp_b   [4] = '{8'h22, 8'h05, 8'h80, 8'h34};
  logic        bp_sub [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [17:0] exp_q  [$];
  logic [17:0] e;
  int          next_op, stall_left, popped;
  int          lat [3];
  int          lat_exp [3] = '{1, 4, 16};

  initial begin
    m8.in_valid = 1'b0; m8.a = 8'h00; m8.b = 8'h00; m8.c_in = 1'b0; m8.sub = 1'b0; m8.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(m8.in_ready), 32'd0);
    chk("rst_outputs", {21'd0, m8.out_valid, m8.ovf, m8.c_out, m8.sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_in_ready", 32'(m8.in_ready), 32'd1);

    // Directed add and subtract vectors
    op8("add_aa55", 8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    op8("add_ffff", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    op8("add_0f01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    op8("add_7f01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("sub_1001", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0);
    op8("sub_0001", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    op8("sub_8001", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    op8("sub_0502", 8'h05, 8'h02, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0);
    flush8();

    // Streaming: six back-to-back operations, with results on consecutive cycles
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      m8.in_valid = (t < 6); m8.out_ready = 1'b1;
      m8.a = st_a[t % 6]; m8.b = st_b[t % 6]; m8.c_in = st_cin[t % 6]; m8.sub = st_sub[t % 6];
      @(posedge clk);
      #1;
      if (t >= 1) begin
        e = model(8, {8'h00, st_a[t-1]}, {8'h00, st_b[t-1]}, st_cin[t-1], st_sub[t-1]);
        chk($sformatf("stream_valid%0d", t - 1), 32'(m8.out_valid), 32'd1);
        chk($sformatf("stream_res%0d", t - 1), {22'd0, m8.ovf, m8.c_out, m8.sum}, {22'd0, e[17:16], e[7:0]});
      end
    end
    flush8();

    // Backpressure: stall five cycles once the first result shows
    next_op = 0; stall_left = 5; popped = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      m8.in_valid = (next_op < 4);
      m8.a = bp_a[next_op % 4]; m8.b = bp_b[next_op % 4]; m8.c_in = 1'b0; m8.sub = bp_sub[next_op % 4];
      if (m8.out_valid && stall_left > 0) begin
        m8.out_ready = 1'b0;
        stall_left--;
      end else begin
        m8.out_ready = 1'b1;
      end
      #1;
      if (!m8.out_ready) begin
        chk("bp_in_ready", 32'(m8.in_ready), 32'd0);
        chk("bp_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          chk("bp_hold", {22'd0, m8.ovf, m8.c_out, m8.sum}, {22'd0, e[17:16], e[7:0]});
        end
      end
      if (m8.out_valid && m8.out_ready) begin
        chk("bp_pop_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk($sformatf("bp_res%0d", popped), {22'd0, m8.ovf, m8.c_out, m8.sum}, {22'd0, e[17:16], e[7:0]});
        end
        popped++;
      end
      if (m8.in_valid && m8.in_ready) begin
        exp_q.push_back(model(8, {8'h00, m8.a}, {8'h00, m8.b}, m8.c_in, m8.sub));
        next_op++;
      end
      @(posedge clk);
    end
    chk("bp_stalled", 32'(stall_left), 32'd0);
    chk("bp_popped", 32'(popped), 32'd4);
    chk("bp_leftover", 32'(exp_q.size()), 32'd0);
    flush8();

    // Reset with two operations in flight
    @(negedge clk);
    m8.a = 8'h21; m8.b = 8'h01; m8.c_in = 1'b0; m8.sub = 1'b0; m8.in_valid = 1'b1; m8.out_ready = 1'b0;
    @(negedge clk);
    m8.a = 8'h03; m8.b = 8'h04;
    @(negedge clk);
    m8.in_valid = 1'b0;
    chk("pre_rst_valid", 32'(m8.out_valid), 32'd1);
    rst_n = 1'b0;
    #1 chk("in_rst_in_ready", 32'(m8.in_ready), 32'd0);
    @(posedge clk);
    #1 chk("mid_rst_outputs", {21'd0, m8.out_valid, m8.ovf, m8.c_out, m8.sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; m8.out_ready = 1'b1;
    #1 chk("post_rst_in_ready", 32'(m8.in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 chk($sformatf("discarded%0d", k), 32'(m8.out_valid), 32'd0);
    end
    op8("post_rst_add", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
    flush8();

    // Sweep: unstalled latency per STAGES, then random traffic against the model
    @(negedge clk);
    sw_a = 16'h1234; sw_b = 16'h0FFF; sw_cin = 1'b0; sw_sub = 1'b0; sw_in_valid = 1'b1; sw_out_ready = 1'b1;
    @(posedge clk);
    lat = '{0, 0, 0};
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      sw_in_valid = 1'b0;
      for (int j = 0; j < 3; j++) begin
        if (lat[j] == 0 && sw_ov[j]) lat[j] = k + 1;
      end
    end
    for (int j = 0; j < 3; j++) chk($sformatf("sweep_latency%0d", j), 32'(lat[j]), 32'(lat_exp[j]));

    for (int cyc = 0; cyc < 1600; cyc++) begin
      @(negedge clk);
      sw_in_valid = ($urandom_range(0, 3) != 0);
      sw_out_ready = ($urandom_range(0, 3) != 0);
      sw_a = 16'($urandom); sw_b = 16'($urandom);
      sw_cin = 1'($urandom_range(0, 1)); sw_sub = 1'($urandom_range(0, 1));
      sweep_cycle("sweep");
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      sw_in_valid = 1'b0; sw_out_ready = 1'b1;
      sweep_cycle("drain");
    end
    for (int j = 0; j < 3; j++) chk($sformatf("sweep_leftover%0d", j), 32'(sw_q[j].size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
